mmio_counter_reader: RTL



---
 rtl/mmio_counter_reader.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mmio_counter_reader.sv
// MMIO responder for the EXM-stage performance counters: a free-running cycle
// counter and a retired-instruction counter, each with a snapshot copy. Loads
// in the window are answered one cycle later. Stores in the window can clear
// the live counters or snapshot them.
module mmio_counter_reader #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        rd_en,
  input  logic [3:0]  wbe,
  input  logic [31:0] addr,
  input  logic [31:0] EXMinst,
  output logic [31:0] rdata,
  output logic        rdata_valid
);

  localparam logic [5:0] OFF_CYCLES      = 6'h10;
  localparam logic [5:0] OFF_INSTS       = 6'h14;
  localparam logic [5:0] OFF_CLEAR       = 6'h18;
  localparam logic [5:0] OFF_SNAP        = 6'h1C;
  localparam logic [5:0] OFF_SNAP_CYCLES = 6'h20;
  localparam logic [5:0] OFF_SNAP_INSTS  = 6'h24;

  logic [31:0] cycles_q,      cycles_d;
  logic [31:0] insts_q,       insts_d;
  logic [31:0] snap_cycles_q, snap_cycles_d;
  logic [31:0] snap_insts_q,  snap_insts_d;
  logic [31:0] rdata_q,       rdata_d;
  logic        rdata_valid_q, rdata_valid_d;

  logic [31:0] off_full;
  logic [5:0]  off;
  logic        in_win;
  logic        is_store;
  logic        st_acc;
  logic        ld_acc;
  logic        do_clear;
  logic        do_snap;
  logic        inst_retired;
  logic [31:0] rd_mux;

  // Window decode and acceptance of loads and stores.
  always_comb begin
    off_full     = addr - BASE_ADDR;
    in_win       = (off_full[31:6] == '0);
    off          = off_full[5:0];
    is_store     = |wbe;
    st_acc       = is_store && !stall && in_win;
    ld_acc       = rd_en && !is_store && !stall && in_win;
    do_clear     = st_acc && (off == OFF_CLEAR);
    do_snap      = st_acc && (off == OFF_SNAP);
    inst_retired = !stall && (EXMinst != NOP_INST);
  end

  // Read mux over the register values held before this edge.
  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_CYCLES:      rd_mux = cycles_q;
      OFF_INSTS:       rd_mux = insts_q;
      OFF_SNAP_CYCLES: rd_mux = snap_cycles_q;
      OFF_SNAP_INSTS:  rd_mux = snap_insts_q;
      default:         rd_mux = '0;
    endcase
  end

  // Next-state for the counters, snapshots, and the registered load response.
  always_comb begin
    cycles_d      = cycles_q + 32'd1;
    insts_d       = inst_retired ? insts_q + 32'd1 : insts_q;
    snap_cycles_d = snap_cycles_q;
    snap_insts_d  = snap_insts_q;
    rdata_d       = rdata_q;
    rdata_valid_d = rdata_valid_q;

    // Clear takes priority over the increment of the same cycle.
    if (do_clear) begin
      cycles_d = '0;
      insts_d  = '0;
    end

    if (do_snap) begin
      snap_cycles_d = cycles_q;
      snap_insts_d  = insts_q;
    end

    // A stall freezes the response. Otherwise a response lasts one cycle, and
    // rdata keeps its last value after rdata_valid drops.
    if (ld_acc) begin
      rdata_d       = rd_mux;
      rdata_valid_d = 1'b1;
    end else if (!stall) begin
      rdata_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycles_q      <= '0;
      insts_q       <= '0;
      snap_cycles_q <= '0;
      snap_insts_q  <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      cycles_q      <= cycles_d;
      insts_q       <= insts_d;
      snap_cycles_q <= snap_cycles_d;
      snap_insts_q  <= snap_insts_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
    end
  end

  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;

endmodule
